// File: rtl/uart_rx_ctrl.sv
// Purpose    : UART receive sequencer. Synchronises the raw Rx line, runs an
//              oversampling baud timer and a start/data/stop FSM, and strobes
//              the external shift register (shift / load_buffer) with the
//              sampled line value on rx_bit. Also flags framing errors.
// Latency    : Rx reaches rx_bit after 2 CLOCKs. The first shift strobe lands
//              in the 96th CLOCK after START entry (defaults), then one strobe
//              every BAUD_DIV*OVERSAMPLE CLOCKs.
// Backpressure: none. The block never stalls; buffer overflow is handled
//              downstream.
// Ports      :
//   CLOCK        in  system clock, all state on the rising edge
//   reset        in  asynchronous active-high reset
//   Rx           in  raw serial line, idle high, asynchronous to CLOCK
//   rx_bit       out synchronised line value, sampled by the shift register on shift
//   shift        out 1-CLOCK strobe: shift rx_bit into the shift register
//   load_buffer  out 1-CLOCK strobe: valid stop bit, move the word to the buffer
//   frame_err    out 1-CLOCK strobe: stop bit sampled low
//   busy         out high in every state except IDLE
module uart_rx_ctrl #(
  parameter int BAUD_DIV   = 4,   // CLOCKs per oversample tick (>=2)
  parameter int OVERSAMPLE = 16,  // oversample ticks per bit (even, >=4)
  parameter int DATA_BITS  = 8    // data bits per frame, LSB first (1..8)
) (
  input  logic CLOCK,
  input  logic reset,
  input  logic Rx,
  output logic rx_bit,
  output logic shift,
  output logic load_buffer,
  output logic frame_err,
  output logic busy
);

  localparam int DIV_W = $clog2(BAUD_DIV);
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic [1:0]       sync_fill_q, sync_fill_d;
  logic             armed_q, armed_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic os_tick;
  logic mid_start;   // tick at the centre of the start bit
  logic bit_end;     // tick at the centre of a data/stop bit

  assign os_tick   = (div_cnt_q == DIV_LAST);
  assign mid_start = os_tick && (os_cnt_q == OS_HALF);
  assign bit_end   = os_tick && (os_cnt_q == OS_LAST);

  // --------------------------------------------------------------------------
  // Two-flop synchroniser. Both flops reset to 1 (idle line), so rx_bit reads
  // 1 straight out of reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= Rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign rx_bit = rx_s_q;

  // The reset value of the synchroniser is not a real observation of the line.
  // sync_fill_q[1] rises once rx_s_q carries a genuinely sampled Rx value, so a
  // line held low through reset cannot arm the receiver via the reset value.
  assign sync_fill_d = {sync_fill_q[0], 1'b1};

  // Arm only after a real high has been seen while idle.
  assign armed_d = armed_q | ((state_q == S_IDLE) && sync_fill_q[1] && rx_s_q);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync_fill_q <= 2'b00;
      armed_q     <= 1'b0;
      div_cnt_q   <= '0;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sync_fill_q <= sync_fill_d;
      armed_q     <= armed_d;
      div_cnt_q   <= div_cnt_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (armed_q && !rx_s_q) state_d = S_START;
      // Line back high at mid start bit: treat as a glitch.
      S_START: if (mid_start) state_d = rx_s_q ? S_IDLE : S_DATA;
      S_DATA:  if (bit_end && (bit_cnt_q == BIT_LAST)) state_d = S_STOP;
      S_STOP:  if (bit_end) state_d = rx_s_q ? S_IDLE : S_BREAK;
      S_BREAK: if (rx_s_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Baud timer and bit counter. Counters are held at zero while idle (and in
  // BREAK), so START always begins with a fresh timer.
  // --------------------------------------------------------------------------
  always_comb begin
    div_cnt_d = div_cnt_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    if ((state_q == S_IDLE) || (state_q == S_BREAK)) begin
      div_cnt_d = '0;
      os_cnt_d  = '0;
      bit_cnt_d = '0;
    end else begin
      div_cnt_d = os_tick ? '0 : div_cnt_q + 1'b1;
      if (os_tick) begin
        // The start bit phase ends at its centre; every following bit ends a
        // full bit period later, keeping sampling on bit centres.
        if (((state_q == S_START) && mid_start) ||
            ((state_q != S_START) && bit_end)) begin
          os_cnt_d = '0;
        end else begin
          os_cnt_d = os_cnt_q + 1'b1;
        end
      end
      if (state_q == S_START) begin
        bit_cnt_d = '0;
      end else if ((state_q == S_DATA) && bit_end) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. Strobes are decoded from state and counters, so each is
  // exactly one CLOCK wide and they are mutually exclusive by state.
  // --------------------------------------------------------------------------
  always_comb begin
    shift       = 1'b0;
    load_buffer = 1'b0;
    frame_err   = 1'b0;
    busy        = (state_q != S_IDLE);
    case (state_q)
      S_DATA: shift = bit_end;
      S_STOP: begin
        load_buffer = bit_end && rx_s_q;
        frame_err   = bit_end && !rx_s_q;
      end
      default: ;
    endcase
  end

endmodule
